// File: rtl/link_control.sv
// Game-loop sequencer for link_char: samples keys once per frame tick, keeps a shadow copy of
// Link's position to refuse moves past the map edges, and orders map redraw before character draw.
module link_control #(
    parameter int unsigned MAP_W         = 256,
    parameter int unsigned MAP_H         = 176,
    parameter int unsigned SPRITE        = 16,
    parameter int unsigned INIT_X        = 127,
    parameter int unsigned INIT_Y        = 88,
    parameter int unsigned MOVE_PERIOD   = 1,
    parameter int unsigned ATTACK_FRAMES = 8,
    parameter int unsigned DRAW_TIMEOUT  = 4096
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_attack,
    input  logic       frame_tick,
    input  logic       map_done,
    input  logic       draw_done,
    output logic       init,
    output logic       idle,
    output logic       attack,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic       draw_char,
    output logic       draw_map,
    output logic [7:0] pos_x,
    output logic [7:0] pos_y,
    output logic       timeout_err,
    output logic       overrun
);

    localparam int unsigned WD_W = $clog2(DRAW_TIMEOUT);
    localparam int unsigned AC_W = $clog2(ATTACK_FRAMES) + 1;

    localparam logic [7:0]      X_MAX    = 8'(MAP_W - SPRITE);
    localparam logic [7:0]      Y_MAX    = 8'(MAP_H - SPRITE);
    localparam logic [7:0]      X0       = 8'(INIT_X);
    localparam logic [7:0]      Y0       = 8'(INIT_Y);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(DRAW_TIMEOUT - 1);
    localparam logic [AC_W-1:0] AC_LOAD  = AC_W'(ATTACK_FRAMES - 1);
    localparam logic [3:0]      DIV_LAST = 4'(MOVE_PERIOD - 1);

    typedef enum logic [3:0] {
        S_START,
        S_INIT,
        S_DRAW_MAP,
        S_DRAW_CHAR,
        S_IDLE,
        S_DECIDE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_MOVE_LEFT,
        S_MOVE_RIGHT,
        S_ATTACK
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      pos_x_nxt, pos_y_nxt;
    logic [WD_W-1:0] wdog, wdog_nxt;
    logic [AC_W-1:0] atk_cnt, atk_cnt_nxt;
    logic [3:0]      move_div, move_div_nxt;
    logic            pending, pending_nxt;
    logic            overrun_nxt, timeout_nxt;

    always_comb begin
        state_nxt    = state;
        pos_x_nxt    = pos_x;
        pos_y_nxt    = pos_y;
        atk_cnt_nxt  = atk_cnt;
        move_div_nxt = move_div;
        pending_nxt  = pending;
        overrun_nxt  = overrun;
        timeout_nxt  = timeout_err;

        if (state != S_IDLE && frame_tick) begin
            if (pending) overrun_nxt = 1'b1;
            pending_nxt = 1'b1;
        end

        unique case (state)
            S_START:     if (start) state_nxt = S_INIT;
            S_INIT: begin
                pos_x_nxt = X0;
                pos_y_nxt = Y0;
                state_nxt = S_DRAW_MAP;
            end
            S_DRAW_MAP: begin
                if (map_done) begin
                    state_nxt = S_DRAW_CHAR;
                end else if (wdog == WD_LAST) begin
                    state_nxt   = S_DRAW_CHAR;
                    timeout_nxt = 1'b1;
                end
            end
            // wdog is zero only on the entry cycle, so a stale draw_done from the previous frame is ignored
            S_DRAW_CHAR: begin
                if (draw_done && wdog != '0) begin
                    state_nxt = S_IDLE;
                end else if (wdog == WD_LAST) begin
                    state_nxt   = S_IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            S_IDLE: begin
                if (frame_tick || pending) begin
                    state_nxt   = S_DECIDE;
                    pending_nxt = 1'b0;
                end
            end
            S_DECIDE: begin
                state_nxt = S_DRAW_MAP;
                if (atk_cnt != '0) begin
                    atk_cnt_nxt = atk_cnt - 1'b1;
                    state_nxt   = S_ATTACK;
                end else if (key_attack) begin
                    atk_cnt_nxt = AC_LOAD;
                    state_nxt   = S_ATTACK;
                end else if (move_div != DIV_LAST) begin
                    move_div_nxt = move_div + 1'b1;
                end else begin
                    move_div_nxt = '0;
                    // only the highest-priority pressed key is considered; if blocked, nothing moves
                    if (key_up) begin
                        if (pos_y != '0) begin
                            state_nxt = S_MOVE_UP;
                            pos_y_nxt = pos_y - 1'b1;
                        end
                    end else if (key_down) begin
                        if (pos_y < Y_MAX) begin
                            state_nxt = S_MOVE_DOWN;
                            pos_y_nxt = pos_y + 1'b1;
                        end
                    end else if (key_left) begin
                        if (pos_x != '0) begin
                            state_nxt = S_MOVE_LEFT;
                            pos_x_nxt = pos_x - 1'b1;
                        end
                    end else if (key_right) begin
                        if (pos_x < X_MAX) begin
                            state_nxt = S_MOVE_RIGHT;
                            pos_x_nxt = pos_x + 1'b1;
                        end
                    end
                end
            end
            S_MOVE_UP, S_MOVE_DOWN, S_MOVE_LEFT, S_MOVE_RIGHT, S_ATTACK:
                state_nxt = S_DRAW_MAP;
            default:     state_nxt = S_START;
        endcase

        if (state_nxt == state && (state == S_DRAW_MAP || state == S_DRAW_CHAR))
            wdog_nxt = wdog + 1'b1;
        else
            wdog_nxt = '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_START;
            pos_x       <= X0;
            pos_y       <= Y0;
            wdog        <= '0;
            atk_cnt     <= '0;
            move_div    <= '0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            init        <= 1'b0;
            idle        <= 1'b0;
            attack      <= 1'b0;
            move_up     <= 1'b0;
            move_down   <= 1'b0;
            move_left   <= 1'b0;
            move_right  <= 1'b0;
            draw_char   <= 1'b0;
            draw_map    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pos_x       <= pos_x_nxt;
            pos_y       <= pos_y_nxt;
            wdog        <= wdog_nxt;
            atk_cnt     <= atk_cnt_nxt;
            move_div    <= move_div_nxt;
            pending     <= pending_nxt;
            overrun     <= overrun_nxt;
            timeout_err <= timeout_nxt;
            init        <= (state_nxt == S_INIT);
            idle        <= (state_nxt == S_IDLE);
            attack      <= (state_nxt == S_ATTACK);
            move_up     <= (state_nxt == S_MOVE_UP);
            move_down   <= (state_nxt == S_MOVE_DOWN);
            move_left   <= (state_nxt == S_MOVE_LEFT);
            move_right  <= (state_nxt == S_MOVE_RIGHT);
            draw_char   <= (state_nxt == S_DRAW_CHAR);
            draw_map    <= (state_nxt == S_DRAW_MAP);
        end
    end

endmodule
